// File: rtl/da_interpolator_phase.sv
// Bit-serial distributed-arithmetic engine for one polyphase branch of an
// upsampling interpolator: y = round_sat(sum COEF[k]*x[k]).
module da_interpolator_phase #(
    parameter int DATA_W    = 8,
    parameter int COEF_W    = 12,
    parameter int NTAPS     = 2,
    parameter int FRAC_BITS = 10,
    parameter logic [NTAPS*COEF_W-1:0] COEFS = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    step_en,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NTAPS*DATA_W-1:0] in_samples,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_sample,
    output logic                    busy
);

    localparam int ACC_W = DATA_W + COEF_W + $clog2(NTAPS) + 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0]        LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;
    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1 << (FRAC_BITS - 1));

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_ROUND
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [DATA_W-1:0]        r_shift [NTAPS];
    logic signed [ACC_W-1:0]  r_acc;
    logic [BIT_W-1:0]         r_bit;
    logic signed [DATA_W-1:0] r_out;
    logic                     r_out_valid;

    logic                     w_accept;
    logic                     w_step;
    logic                     w_last;
    logic signed [ACC_W-1:0]  w_coef [NTAPS];
    logic signed [ACC_W-1:0]  w_psum;
    logic signed [ACC_W-1:0]  w_term;
    logic signed [ACC_W-1:0]  w_rnd;
    logic signed [ACC_W-1:0]  w_scaled;
    logic signed [DATA_W-1:0] w_sat;

    // Sign-extend each constant coefficient to accumulator width.
    for (genvar k = 0; k < NTAPS; k++) begin : g_coef
        assign w_coef[k] = {{(ACC_W - COEF_W){COEFS[k*COEF_W + COEF_W - 1]}},
                            COEFS[k*COEF_W +: COEF_W]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        busy     = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (step_en && (r_bit == LAST_BIT)) begin
                    w_next = S_ROUND;
                end
            end
            S_ROUND: begin
                busy   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_step   = (r_state == S_RUN) && step_en;
    assign w_last   = (r_bit == LAST_BIT);

    // Partial product for the current bit plane: sum of coefficients whose
    // sample bit is set.
    always_comb begin
        w_psum = '0;
        for (int unsigned k = 0; k < NTAPS; k++) begin
            if (r_shift[k][0]) begin
                w_psum = w_psum + w_coef[k];
            end
        end
    end

    assign w_term   = w_psum <<< r_bit;
    assign w_rnd    = r_acc + RND_HALF;
    assign w_scaled = w_rnd >>> FRAC_BITS;

    always_comb begin
        w_sat = w_scaled[DATA_W-1:0];
        if (w_scaled > SAT_MAX) begin
            w_sat = SAT_MAX[DATA_W-1:0];
        end else if (w_scaled < SAT_MIN) begin
            w_sat = SAT_MIN[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc       <= '0;
            r_bit       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            for (int unsigned k = 0; k < NTAPS; k++) begin
                r_shift[k] <= '0;
            end
        end else begin
            r_out_valid <= 1'b0;
            if (w_accept) begin
                r_acc <= '0;
                r_bit <= '0;
                for (int unsigned k = 0; k < NTAPS; k++) begin
                    r_shift[k] <= in_samples[k*DATA_W +: DATA_W];
                end
            end else if (w_step) begin
                // MSB plane carries the negative two's-complement weight.
                if (w_last) begin
                    r_acc <= r_acc - w_term;
                    r_bit <= '0;
                end else begin
                    r_acc <= r_acc + w_term;
                    r_bit <= r_bit + BIT_W'(1);
                end
                for (int unsigned k = 0; k < NTAPS; k++) begin
                    r_shift[k] <= r_shift[k] >> 1;
                end
            end
            if (r_state == S_ROUND) begin
                r_out       <= w_sat;
                r_out_valid <= 1'b1;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_sample = r_out;

endmodule

// File: tb/tb_da_interpolator_phase.sv
// Bench for da_interpolator_phase: three instances (two 2-tap configs and a
// 4-tap config) driven by shared control, checked against an integer model.
module tb_da_interpolator_phase;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        reset, step_en, in_valid;
    logic [15:0] s2;
    logic [31:0] s4;
    logic        rdy0, rdy1, rdy2, ov0, ov1, ov2, busy0, busy1, busy2;
    logic [7:0]  os0, os1, os2;

    da_interpolator_phase #(.DATA_W(8), .COEF_W(12), .NTAPS(2), .FRAC_BITS(10),
        .COEFS({12'd512, 12'd512})) u0 (
        .clk(clk), .reset(reset), .step_en(step_en), .in_valid(in_valid),
        .in_ready(rdy0), .in_samples(s2), .out_valid(ov0), .out_sample(os0),
        .busy(busy0));

    da_interpolator_phase #(.DATA_W(8), .COEF_W(12), .NTAPS(2), .FRAC_BITS(10),
        .COEFS({12'd1023, 12'd1023})) u1 (
        .clk(clk), .reset(reset), .step_en(step_en), .in_valid(in_valid),
        .in_ready(rdy1), .in_samples(s2), .out_valid(ov1), .out_sample(os1),
        .busy(busy1));

    // Tap 0 at the LSB end: COEF = {-256, 512, 1023, -1} for taps 0..3.
    da_interpolator_phase #(.DATA_W(8), .COEF_W(12), .NTAPS(4), .FRAC_BITS(10),
        .COEFS({12'hFFF, 12'd1023, 12'd512, 12'hF00})) u2 (
        .clk(clk), .reset(reset), .step_en(step_en), .in_valid(in_valid),
        .in_ready(rdy2), .in_samples(s4), .out_valid(ov2), .out_sample(os2),
        .busy(busy2));

    int total = 0;
    int bad   = 0;

    int C0[4] = '{512, 512, 0, 0};
    int C1[4] = '{1023, 1023, 0, 0};
    int C2[4] = '{-256, 512, 1023, -1};
    int cx2[4];
    int cx4[4];

    typedef struct {
        int a0;
        int a1;
        int q[4];
        int e0;
        int e1;
        int e2;
    } vec_t;

    vec_t vt[9];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Exact integer sum, round half toward +inf via floor division, clamp.
    function automatic int model(input int x[4], input int c[4]);
        int acc, t, r;
        acc = 0;
        for (int i = 0; i < 4; i++) acc += x[i] * c[i];
        t = acc + 512;
        if (t >= 0) r = t / 1024;
        else        r = -((-t + 1023) / 1024);
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    function automatic int sx(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    task automatic present(input int a0, input int a1, input int q[4]);
        int b0, b1;
        b0 = a0; b1 = a1;
        s2 = {b1[7:0], b0[7:0]};
        s4 = 32'(0);
        for (int i = 0; i < 4; i++) begin
            int v;
            v = q[i];
            s4[i*8 +: 8] = v[7:0];
        end
        cx2 = '{a0, a1, 0, 0};
        cx4 = q;
        in_valid = 1'b1;
    endtask

    // Called at a negedge with inputs presented; accept happens on the next edge.
    task automatic run(input int stall_at, input int stall_len, input bit noise,
                       output int lat, output int o0, output int o1, output int o2);
        int t0, prev;
        lat = -1; o0 = 0; o1 = 0; o2 = 0;
        prev = sx(os0);
        check("accept_ready", int'(rdy0), 1);
        t0 = cyc;
        for (int k = 1; k <= 60 && lat < 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("busy_after_accept", int'(busy0), 1);
                check("out_held_while_busy", sx(os0), prev);
            end
            if (ov0) begin
                lat = cyc - t0;
                o0 = sx(os0); o1 = sx(os1); o2 = sx(os2);
                check("ov_lockstep", int'(ov1 & ov2), 1);
                check("ready_in_ov_cycle", int'(rdy0), 1);
            end else begin
                if (noise) begin
                    in_valid = 1'($urandom_range(0, 1));
                    s2 = 16'($urandom);
                    s4 = $urandom;
                end
                step_en = !(stall_at > 0 && k >= stall_at && k < stall_at + stall_len);
            end
        end
        step_en  = 1'b1;
        in_valid = 1'b0;
        if (lat < 0) check("out_valid_timeout", 0, 1);
    endtask

    initial begin
        int lat, o0, o1, o2, cnt, st, sl;
        int z[4];
        int q[4];
        z = '{0, 0, 0, 0};

        vt[0] = '{100, 50, '{0, 0, 0, 0}, 75, 127, 0};
        vt[1] = '{3, 0, '{0, 0, 0, 0}, 2, 3, 0};
        vt[2] = '{-3, 0, '{0, 0, 0, 0}, -1, -3, 0};
        vt[3] = '{-128, 0, '{0, 0, 0, 0}, -64, -128, 0};
        vt[4] = '{127, 127, '{0, 0, 0, 0}, 127, 127, 0};
        vt[5] = '{-128, -128, '{0, 0, 0, 0}, -128, -128, 0};
        vt[6] = '{1, 0, '{0, 0, 0, 0}, 1, 1, 0};
        vt[7] = '{0, -1, '{0, 0, 0, 0}, 0, -1, 0};
        // Exact 4-tap sum 17930 -> (17930+512)>>10 = 18.
        vt[8] = '{0, 0, '{10, -20, 30, -40}, 0, 0, 18};

        // Reset together with in_valid: nothing may be accepted.
        reset = 1'b1; step_en = 1'b1;
        present(100, 50, z);
        repeat (3) @(negedge clk);
        check("reset_busy", int'(busy0), 0);
        check("reset_out_valid", int'(ov0), 0);
        check("reset_out_sample", sx(os0), 0);
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("ready_after_reset", int'(rdy0), 1);
        check("idle_after_reset", int'(busy0), 0);

        for (int i = 0; i < 9; i++) begin
            present(vt[i].a0, vt[i].a1, vt[i].q);
            run(0, 0, 1'b1, lat, o0, o1, o2);
            check("vec_latency", lat, 10);
            check("vec_u0", o0, vt[i].e0);
            check("vec_u1", o1, vt[i].e1);
            check("vec_u2", o2, vt[i].e2);
            @(negedge clk);
            check("vec_pulse_width", int'(ov0), 0);
            check("vec_out_held", sx(os0), vt[i].e0);
        end

        // Three-cycle stall mid-RUN stretches latency to 13.
        present(100, 50, z);
        run(3, 3, 1'b1, lat, o0, o1, o2);
        check("stall_latency", lat, 13);
        check("stall_value", o0, 75);
        @(negedge clk);

        // Back-to-back: in_valid held, next accept coincides with out_valid.
        present(100, 50, z);
        run(0, 0, 1'b0, lat, o0, o1, o2);
        check("b2b_first_latency", lat, 10);
        check("b2b_first_value", o0, 75);
        present(3, 0, z);
        run(0, 0, 1'b0, lat, o0, o1, o2);
        check("b2b_second_latency", lat, 10);
        check("b2b_second_value", o0, 2);
        @(negedge clk);

        // Reset mid-operation discards the computation.
        present(100, 50, z);
        check("rst_accept_ready", int'(rdy0), 1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            reset = (k == 3);
        end
        check("midrst_out_sample", sx(os0), 0);
        check("midrst_ready", int'(rdy0), 1);
        check("midrst_busy", int'(busy0), 0);
        cnt = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (ov0 || ov1 || ov2) cnt++;
        end
        check("midrst_no_out_valid", cnt, 0);
        present(100, 50, z);
        run(0, 0, 1'b1, lat, o0, o1, o2);
        check("midrst_fresh_latency", lat, 10);
        check("midrst_fresh_value", o0, 75);
        @(negedge clk);

        // Randomised samples and stalls against the model.
        for (int i = 0; i < 24; i++) begin
            int a0, a1;
            a0 = int'($urandom_range(0, 255)) - 128;
            a1 = int'($urandom_range(0, 255)) - 128;
            for (int j = 0; j < 4; j++) q[j] = int'($urandom_range(0, 255)) - 128;
            st = int'($urandom_range(1, 6));
            sl = int'($urandom_range(0, 3));
            present(a0, a1, q);
            run(st, sl, 1'b1, lat, o0, o1, o2);
            check("rnd_latency", lat, 10 + sl);
            check("rnd_u0", o0, model(cx2, C0));
            check("rnd_u1", o1, model(cx2, C1));
            check("rnd_u2", o2, model(cx4, C2));
            @(negedge clk);
            check("rnd_pulse_width", int'(ov0), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
